pipeline_hazard_ctrl: RTL

Central stall/flush scheduler for the five-stage CPU pipeline. It watches ID-stage source registers, the ID/EX load destination, the EX branch outcome, the ID jump decode and the MEM-stage data-memory handshake. From these it drives per-stage enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A small FSM freezes the whole pipeline during multi-cycle data-memory accesses, with a timeout to a sticky error state, and two saturating performance counters record stall and flush cycles.

---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs and per-stage enable/flush outputs.
// The controller connects through the slave modport; the pipeline side uses master.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rt_addr;
    logic             ex_branch_taken;
    logic             ex_mem_memread;
    logic             ex_mem_memwrite;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_ex_memread,
               id_ex_rt_addr, ex_branch_taken, ex_mem_memread, ex_mem_memwrite,
               dmem_ready,
        input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
               id_ex_flush, mem_wb_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_ex_memread,
               id_ex_rt_addr, ex_branch_taken, ex_mem_memread, ex_mem_memwrite,
               dmem_ready,
        output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
               id_ex_flush, mem_wb_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: combinational stage controls,
// memory-wait FSM with timeout to a sticky error, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_acc, w_pend, w_err, w_freeze, w_load_use, w_stall;
    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en;
    logic w_if_id_flush, w_id_ex_flush, w_mem_wb_flush;

    assign w_mem_acc  = bus.ex_mem_memread | bus.ex_mem_memwrite;
    assign w_pend     = w_mem_acc & ~bus.dmem_ready;
    assign w_err      = (r_state == ERROR);
    assign w_freeze   = w_pend | w_err;
    assign w_load_use = bus.id_ex_memread & (bus.id_ex_rt_addr != 5'd0) &
                        ((bus.id_uses_rs & (bus.id_rs == bus.id_ex_rt_addr)) |
                         (bus.id_uses_rt & (bus.id_rt == bus.id_ex_rt_addr)));
    assign w_stall    = w_freeze | (w_load_use & ~bus.ex_branch_taken);

    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_id_ex_en     = 1'b1;
        w_ex_mem_en    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (w_freeze) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
            w_if_id_flush = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_pend) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready || !w_mem_acc) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == TIMEOUT_V) begin
                    w_state_nxt = ERROR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            ERROR:   w_state_nxt = ERROR;
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_if_id_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.dmem_req     = w_mem_acc & ~w_err;
    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.mem_err      = w_err;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
endmodule
